// File: rtl/sweep_pkg.sv
// +----------------------------------------------------------------------------+
// | sweep_pkg: shared types and constants for the truth-table sweeper          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int         DEFAULT_N_IN      = 3;
  localparam int         TIMER_W           = 8;
  // Expected table for AB' + C'(A+B) with A=bit0, B=bit1, C=bit2.
  localparam logic [7:0] DEFAULT_EXP_TABLE = 8'h2E;

  function automatic int table_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
// +----------------------------------------------------------------------------+
// | truth_table_sweeper_if: control, function-drive and result signals         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface truth_table_sweeper_if
  import sweep_pkg::*;
#(
  parameter int N_IN = DEFAULT_N_IN
);
  localparam int TW = table_width(N_IN);

  logic            start;
  logic            abort;
  logic            func_out;
  logic [N_IN-1:0] func_in;
  logic            busy;
  logic            done;
  logic [TW-1:0]   truth_table;
  logic [TW-1:0]   mismatch;
  logic            pass;

  modport master (
    output start, abort, func_out,
    input  func_in, busy, done, truth_table, mismatch, pass
  );

  modport slave (
    input  start, abort, func_out,
    output func_in, busy, done, truth_table, mismatch, pass
  );

endinterface

`default_nettype wire

// File: rtl/settle_timer.sv
// +----------------------------------------------------------------------------+
// | settle_timer: 8-bit loadable down-counter, expire flags the final count    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module settle_timer
  import sweep_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               load,
  input  wire logic [TIMER_W-1:0] load_val,
  input  wire logic               dec,
  output logic                    expire
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign expire = (count_q == TIMER_W'(1));

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// +----------------------------------------------------------------------------+
// | truth_table_sweeper: steps a function through all inputs, captures and     |
// | compares its truth table. Rev 1.0 - initial release                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                            N_IN          = DEFAULT_N_IN,
  parameter int                            SETTLE_CYCLES = 2,
  parameter logic [table_width(N_IN)-1:0]  EXP_TABLE     = DEFAULT_EXP_TABLE
)(
  input  wire logic              clk,
  input  wire logic              rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int                 TW          = table_width(N_IN);
  localparam logic [N_IN-1:0]    LAST_IDX    = N_IN'(TW - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES);

  state_t          state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] func_in_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [TW-1:0]   tt_q;
  logic [TW-1:0]   mm_q;

  logic            accept;
  logic            aborting;
  logic            timer_load;
  logic            timer_dec;
  logic            timer_expire;
  logic [N_IN-1:0] idx_d;
  logic [TW-1:0]   tt_d;

  assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
  assign aborting = busy_q && bus.abort;
  assign idx_d    = idx_q + N_IN'(1);

  always_comb begin
    tt_d        = tt_q;
    tt_d[idx_q] = bus.func_out;
  end

  // Reload on acceptance and on every non-final sample so each vector settles fully.
  assign timer_load = accept ||
                      ((state_q == SAMPLE) && !bus.abort && (idx_q != LAST_IDX));
  assign timer_dec  = (state_q == SETTLE) && !timer_expire;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      func_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      tt_q      <= '0;
      mm_q      <= '0;
    end else if (aborting) begin
      state_q   <= IDLE;
      func_in_q <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SETTLE;
            idx_q     <= '0;
            func_in_q <= '0;
            busy_q    <= 1'b1;
            tt_q      <= '0;
            mm_q      <= '0;
            pass_q    <= 1'b0;
          end
        end
        SETTLE: begin
          if (timer_expire) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt_q <= tt_d;
          // Results are registered with the final capture so they line up with done.
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            mm_q    <= tt_d ^ EXP_TABLE;
            pass_q  <= (tt_d == EXP_TABLE);
          end else begin
            idx_q     <= idx_d;
            func_in_q <= idx_d;
            state_q   <= SETTLE;
          end
        end
        DONE: begin
          done_q    <= 1'b0;
          func_in_q <= '0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.func_in     = func_in_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.mismatch    = mm_q;
  assign bus.pass        = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// +----------------------------------------------------------------------------+
// | tb_truth_table_sweeper: scoreboard bench, default and SETTLE_CYCLES=1 DUTs |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] tt;
    logic [7:0] mm;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic zero_a;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  truth_table_sweeper_if #(.N_IN(3)) if_a ();
  truth_table_sweeper_if #(.N_IN(3)) if_b ();

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2), .EXP_TABLE(8'h2E)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a.slave)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1), .EXP_TABLE(8'h2E)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b.slave)
  );

  // Gate-level AB' + C'(A+B)
  assign if_a.func_out = zero_a ? 1'b0 :
      ((if_a.func_in[0] & ~if_a.func_in[1]) | (~if_a.func_in[2] & (if_a.func_in[0] | if_a.func_in[1])));
  assign if_b.func_out =
      ((if_b.func_in[0] & ~if_b.func_in[1]) | (~if_b.func_in[2] & (if_b.func_in[0] | if_b.func_in[1])));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_a.done === 1'b1) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done_a: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        check("a_truth_table", 32'(if_a.truth_table), 32'(ea.tt));
        check("a_mismatch",    32'(if_a.mismatch),    32'(ea.mm));
        check("a_pass",        32'(if_a.pass),        32'(ea.pass));
        check("a_done_edge",   32'(cyc),              32'(ea.done_cyc));
        check("a_busy_in_done", 32'(if_a.busy),       32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.done === 1'b1) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done_b: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        check("b_truth_table", 32'(if_b.truth_table), 32'(eb.tt));
        check("b_mismatch",    32'(if_b.mismatch),    32'(eb.mm));
        check("b_pass",        32'(if_b.pass),        32'(eb.pass));
        check("b_done_edge",   32'(cyc),              32'(eb.done_cyc));
      end
    end
  end

  // One-cycle start pulse; returns at the negedge right after the accepting edge.
  task automatic start_pulse(input bit sel_b, input bit do_push,
                             input logic [7:0] tt, input logic [7:0] mm, input logic ps);
    exp_t e;
    @(negedge clk);
    if (sel_b) if_b.start = 1'b1; else if_a.start = 1'b1;
    if (do_push) begin
      e.tt = tt;
      e.mm = mm;
      e.pass = ps;
      e.done_cyc = cyc + 1 + (sel_b ? 16 : 24);
      if (sel_b) qb.push_back(e); else qa.push_back(e);
    end
    @(negedge clk);
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  task automatic drain(input bit sel_b);
    for (int i = 0; i < 100; i++) begin
      if ((sel_b ? qb.size() : qa.size()) == 0) break;
      @(negedge clk);
    end
    if ((sel_b ? qb.size() : qa.size()) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout_%s: got no done, expected done within 100 cycles", sel_b ? "b" : "a");
      if (sel_b) qb.delete(); else qa.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    zero_a  = 1'b0;
    rst_n   = 1'b0;
    if_a.start = 1'b0; if_a.abort = 1'b0;
    if_b.start = 1'b0; if_b.abort = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_func_in", 32'(if_a.func_in), 32'd0);
    check("rst_busy",    32'(if_a.busy),    32'd0);
    check("rst_done",    32'(if_a.done),    32'd0);
    check("rst_tt",      32'(if_a.truth_table), 32'd0);
    check("rst_mm",      32'(if_a.mismatch), 32'd0);
    check("rst_pass",    32'(if_a.pass),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep against the real function, func_in stepping every 3 cycles
    start_pulse(1'b0, 1'b1, 8'h2E, 8'h00, 1'b1);
    for (int j = 0; j < 24; j++) begin
      if (j % 3 == 0) begin
        check("a_func_in_step", 32'(if_a.func_in), 32'(j / 3));
        check("a_busy_sweep",   32'(if_a.busy),    32'd1);
      end
      @(negedge clk);
    end
    drain(1'b0);
    check("a_busy_after", 32'(if_a.busy), 32'd0);
    check("a_hold_pass",  32'(if_a.pass), 32'd1);

    // Output stuck at 0
    zero_a = 1'b1;
    start_pulse(1'b0, 1'b1, 8'h00, 8'h2E, 1'b0);
    drain(1'b0);
    zero_a = 1'b0;

    // Abort at idx=3
    start_pulse(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (9) @(negedge clk);
    check("a_idx3_before_abort", 32'(if_a.func_in), 32'd3);
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    check("abort_busy",    32'(if_a.busy),        32'd0);
    check("abort_func_in", 32'(if_a.func_in),     32'd0);
    check("abort_tt",      32'(if_a.truth_table), 32'h06);
    check("abort_pass",    32'(if_a.pass),        32'd0);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", 32'(if_a.busy), 32'd0);

    // start and abort together in IDLE
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    check("start_abort_busy", 32'(if_a.busy), 32'd0);
    repeat (5) @(negedge clk);

    // start re-pulsed at idx=5 is ignored
    start_pulse(1'b0, 1'b1, 8'h2E, 8'h00, 1'b1);
    repeat (15) @(negedge clk);
    check("a_idx5_restart", 32'(if_a.func_in), 32'd5);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    drain(1'b0);
    repeat (30) @(negedge clk);

    // Reset mid-sweep at idx=4, then a fresh sweep
    start_pulse(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (12) @(negedge clk);
    check("a_idx4_before_rst", 32'(if_a.func_in), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_func_in", 32'(if_a.func_in),     32'd0);
    check("midrst_busy",    32'(if_a.busy),        32'd0);
    check("midrst_done",    32'(if_a.done),        32'd0);
    check("midrst_tt",      32'(if_a.truth_table), 32'd0);
    check("midrst_pass",    32'(if_a.pass),        32'd0);
    start_pulse(1'b0, 1'b1, 8'h2E, 8'h00, 1'b1);
    drain(1'b0);

    // SETTLE_CYCLES=1 build steps every 2 cycles
    start_pulse(1'b1, 1'b1, 8'h2E, 8'h00, 1'b1);
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) check("b_func_in_step", 32'(if_b.func_in), 32'(j / 2));
      @(negedge clk);
    end
    drain(1'b1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
